// File: rtl/dmem_arbiter_if.sv
// Bundle of requester-side and RAM-side signals around the data-RAM arbiter.
// The slave modport is the arbiter; the master modport is everything around it.
interface dmem_arbiter_if #(
    parameter int ADDR_W = 12,
    parameter int DATA_W = 32
);
    logic              req0;
    logic              req1;
    logic              we0;
    logic              we1;
    logic [ADDR_W-1:0] addr0;
    logic [ADDR_W-1:0] addr1;
    logic [DATA_W-1:0] wdata0;
    logic [DATA_W-1:0] wdata1;
    logic              lock1;
    logic              gnt0;
    logic              gnt1;
    logic              stall0;
    logic              rvalid0;
    logic              rvalid1;
    logic [DATA_W-1:0] rdata0;
    logic [DATA_W-1:0] rdata1;
    logic              ram_wEn;
    logic [ADDR_W-1:0] ram_addr;
    logic [DATA_W-1:0] ram_dataIn;
    logic [DATA_W-1:0] ram_dataOut;

    modport slave (
        input  req0, req1, we0, we1, addr0, addr1, wdata0, wdata1, lock1, ram_dataOut,
        output gnt0, gnt1, stall0, rvalid0, rvalid1, rdata0, rdata1,
               ram_wEn, ram_addr, ram_dataIn
    );

    modport master (
        output req0, req1, we0, we1, addr0, addr1, wdata0, wdata1, lock1, ram_dataOut,
        input  gnt0, gnt1, stall0, rvalid0, rvalid1, rdata0, rdata1,
               ram_wEn, ram_addr, ram_dataIn
    );
endinterface

// File: rtl/dmem_arbiter.sv
// Round-robin arbiter sharing one synchronous-read data RAM between the CPU
// memory stage (port 0) and a secondary master (port 1) with bounded burst lock.
module dmem_arbiter #(
    parameter int ADDR_W    = 12,
    parameter int DATA_W    = 32,
    parameter int MAX_BURST = 4
) (
    input  logic          clock,
    input  logic          reset,
    dmem_arbiter_if.slave bus
);
    localparam int             CNT_W   = $clog2(MAX_BURST + 1);
    localparam logic [CNT_W-1:0] MAX_CNT = CNT_W'(MAX_BURST);

    logic             last_r;
    logic             last_nxt_s;
    logic [CNT_W-1:0] burst_cnt_r;
    logic [CNT_W-1:0] burst_cnt_nxt_s;
    logic             rd_pending0_r;
    logic             rd_pending1_r;
    logic             rd_pending0_nxt_s;
    logic             rd_pending1_nxt_s;
    logic             gnt0_s;
    logic             gnt1_s;
    logic             ram_wen_s;
    logic [ADDR_W-1:0] ram_addr_s;
    logic [DATA_W-1:0] ram_din_s;

    // State register: arbitration history and read tags
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            last_r        <= 1'b1;
            burst_cnt_r   <= {CNT_W{1'b0}};
            rd_pending0_r <= 1'b0;
            rd_pending1_r <= 1'b0;
        end else begin
            last_r        <= last_nxt_s;
            burst_cnt_r   <= burst_cnt_nxt_s;
            rd_pending0_r <= rd_pending0_nxt_s;
            rd_pending1_r <= rd_pending1_nxt_s;
        end
    end

    // Grant selection: lock gives port 1 priority until the burst budget runs out
    always_comb begin
        gnt0_s = 1'b0;
        gnt1_s = 1'b0;
        if (reset) begin
            gnt0_s = 1'b0;
            gnt1_s = 1'b0;
        end else if (bus.req0 && bus.req1) begin
            if (bus.lock1 && (burst_cnt_r < MAX_CNT)) begin
                gnt1_s = 1'b1;
            end else begin
                gnt0_s = last_r;
                gnt1_s = ~last_r;
            end
        end else begin
            gnt0_s = bus.req0;
            gnt1_s = bus.req1;
        end
    end

    // Next-state: history update and read tagging
    always_comb begin
        last_nxt_s      = last_r;
        burst_cnt_nxt_s = burst_cnt_r;
        if (gnt0_s) begin
            last_nxt_s = 1'b0;
        end else if (gnt1_s) begin
            last_nxt_s = 1'b1;
        end else begin
            last_nxt_s = last_r;
        end
        if (gnt0_s || !bus.lock1) begin
            burst_cnt_nxt_s = {CNT_W{1'b0}};
        end else if (gnt1_s && bus.req0 && (burst_cnt_r < MAX_CNT)) begin
            burst_cnt_nxt_s = burst_cnt_r + CNT_W'(1'b1);
        end else begin
            burst_cnt_nxt_s = burst_cnt_r;
        end
        rd_pending0_nxt_s = gnt0_s & ~bus.we0;
        rd_pending1_nxt_s = gnt1_s & ~bus.we1;
    end

    // RAM drive: mux of the granted port, all zero when idle
    always_comb begin
        ram_wen_s  = 1'b0;
        ram_addr_s = {ADDR_W{1'b0}};
        ram_din_s  = {DATA_W{1'b0}};
        case ({gnt1_s, gnt0_s})
            2'b01: begin
                ram_wen_s  = bus.we0;
                ram_addr_s = bus.addr0;
                ram_din_s  = bus.wdata0;
            end
            2'b10: begin
                ram_wen_s  = bus.we1;
                ram_addr_s = bus.addr1;
                ram_din_s  = bus.wdata1;
            end
            default: begin
                ram_wen_s  = 1'b0;
                ram_addr_s = {ADDR_W{1'b0}};
                ram_din_s  = {DATA_W{1'b0}};
            end
        endcase
    end

    assign bus.gnt0       = gnt0_s;
    assign bus.gnt1       = gnt1_s;
    assign bus.stall0     = bus.req0 & ~gnt0_s;
    assign bus.ram_wEn    = ram_wen_s;
    assign bus.ram_addr   = ram_addr_s;
    assign bus.ram_dataIn = ram_din_s;
    assign bus.rvalid0    = rd_pending0_r;
    assign bus.rvalid1    = rd_pending1_r;
    // Read data is steered only to the port that owns the returning read
    assign bus.rdata0     = rd_pending0_r ? bus.ram_dataOut : {DATA_W{1'b0}};
    assign bus.rdata1     = rd_pending1_r ? bus.ram_dataOut : {DATA_W{1'b0}};
endmodule

// File: tb/tb_dmem_arbiter.sv
// Randomized and directed bench for dmem_arbiter against a behavioural model
// with a RAM model and a per-port expected-read scoreboard.
module tb_dmem_arbiter;
    localparam int ADDR_W    = 12;
    localparam int DATA_W    = 32;
    localparam int MAX_BURST = 4;

    logic clock = 1'b0;
    logic reset;
    logic ram_clr;
    always #5 clock = ~clock;

    dmem_arbiter_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus ();

    dmem_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .MAX_BURST(MAX_BURST)) dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus)
    );

    // Synchronous-read single-port RAM
    logic [DATA_W-1:0] ram_mem [0:4095];
    always @(posedge clock) begin
        if (ram_clr) begin
            for (int i = 0; i < 4096; i++) ram_mem[i] <= 32'h0;
        end else if (bus.ram_wEn) begin
            ram_mem[bus.ram_addr] <= bus.ram_dataIn;
        end
        bus.ram_dataOut <= ram_mem[bus.ram_addr];
    end

    // Reference model state
    logic [DATA_W-1:0] m_mem [logic [ADDR_W-1:0]];
    int                m_last;
    int                m_run;
    logic              exp_rv0, exp_rv1;
    logic [DATA_W-1:0] exp_rd0, exp_rd1;
    logic              obs_g0, obs_stall;
    int                n_tests = 0;
    int                n_fail  = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic logic [DATA_W-1:0] mrd(input logic [ADDR_W-1:0] a);
        return m_mem.exists(a) ? m_mem[a] : 32'h0;
    endfunction

    task automatic model_reset();
        m_last  = 1;
        m_run   = 0;
        exp_rv0 = 1'b0;
        exp_rv1 = 1'b0;
        exp_rd0 = 32'h0;
        exp_rd1 = 32'h0;
    endtask

    task automatic idle_inputs();
        bus.req0 = 1'b0; bus.we0 = 1'b0; bus.addr0 = 12'h0; bus.wdata0 = 32'h0;
        bus.req1 = 1'b0; bus.we1 = 1'b0; bus.addr1 = 12'h0; bus.wdata1 = 32'h0;
        bus.lock1 = 1'b0;
    endtask

    // Called just after a falling edge with inputs set; checks, advances model one cycle
    task automatic step(output int w);
        logic              e_wen;
        logic [ADDR_W-1:0] e_addr;
        logic [DATA_W-1:0] e_din;
        #1;
        if (reset) w = -1;
        else if (bus.req0 && bus.req1) begin
            if (bus.lock1 && m_run < MAX_BURST) w = 1;
            else w = (m_last == 0) ? 1 : 0;
        end
        else if (bus.req0) w = 0;
        else if (bus.req1) w = 1;
        else w = -1;
        e_wen  = (w == 0) ? bus.we0    : (w == 1) ? bus.we1    : 1'b0;
        e_addr = (w == 0) ? bus.addr0  : (w == 1) ? bus.addr1  : 12'h0;
        e_din  = (w == 0) ? bus.wdata0 : (w == 1) ? bus.wdata1 : 32'h0;
        check("gnt0", bus.gnt0, w == 0);
        check("gnt1", bus.gnt1, w == 1);
        check("stall0", bus.stall0, bus.req0 && (w != 0));
        check("ram_wEn", bus.ram_wEn, e_wen);
        check("ram_addr", bus.ram_addr, e_addr);
        check("ram_dataIn", bus.ram_dataIn, e_din);
        check("rvalid0", bus.rvalid0, exp_rv0);
        check("rvalid1", bus.rvalid1, exp_rv1);
        check("rdata0", bus.rdata0, exp_rv0 ? exp_rd0 : 32'h0);
        check("rdata1", bus.rdata1, exp_rv1 ? exp_rd1 : 32'h0);
        obs_g0    = bus.gnt0;
        obs_stall = bus.stall0;
        if (reset) begin
            model_reset();
        end else begin
            exp_rv0 = (w == 0) && !bus.we0;
            exp_rv1 = (w == 1) && !bus.we1;
            exp_rd0 = mrd(bus.addr0);
            exp_rd1 = mrd(bus.addr1);
            if (w == 0 && bus.we0) m_mem[bus.addr0] = bus.wdata0;
            if (w == 1 && bus.we1) m_mem[bus.addr1] = bus.wdata1;
            if (w == 0 || !bus.lock1) m_run = 0;
            else if (w == 1 && bus.req0 && m_run < MAX_BURST) m_run = m_run + 1;
            if (w >= 0) m_last = w;
        end
        @(negedge clock);
    endtask

    task automatic pulse_reset();
        idle_inputs();
        reset = 1'b1;
        @(negedge clock);
        reset = 1'b0;
        model_reset();
    endtask

    initial begin
        int w;
        int stalls;
        logic p0_act, p1_act;
        idle_inputs();
        model_reset();
        reset   = 1'b1;
        ram_clr = 1'b1;
        repeat (2) @(posedge clock);
        @(negedge clock);
        reset   = 1'b0;
        ram_clr = 1'b0;

        // Idle after reset
        step(w);

        // Port 0 write then read of the same word
        bus.req0 = 1'b1; bus.we0 = 1'b1; bus.addr0 = 12'h010; bus.wdata0 = 32'hDEADBEEF;
        step(w);
        check("p0_wr_gnt", obs_g0, 1'b1);
        bus.we0 = 1'b0;
        step(w);
        check("p0_rd_gnt", obs_g0, 1'b1);
        bus.req0 = 1'b0;
        #1;
        check("p0_rdata_dead", bus.rdata0, 32'hDEADBEEF);
        check("p0_rv1_quiet", bus.rvalid1, 1'b0);
        step(w);

        // Contested reads without lock alternate starting with port 0
        pulse_reset();
        bus.req0 = 1'b1; bus.addr0 = 12'h001;
        bus.req1 = 1'b1; bus.addr1 = 12'h002;
        for (int i = 0; i < 6; i++) begin
            step(w);
            check("rr_alternate", obs_g0, (i % 2) == 0);
        end
        idle_inputs();
        step(w);

        // Lock burst: four port-1 grants, then port 0
        pulse_reset();
        bus.req0 = 1'b1; bus.addr0 = 12'h003;
        bus.req1 = 1'b1; bus.addr1 = 12'h004; bus.lock1 = 1'b1;
        stalls = 0;
        for (int i = 0; i < 5; i++) begin
            step(w);
            if (obs_stall) stalls++;
            check("lock_gnt0", obs_g0, i == 4);
        end
        check("lock_stall_cycles", stalls, 4);
        idle_inputs();
        step(w);

        // Reset during a pending port-1 read
        pulse_reset();
        bus.req1 = 1'b1; bus.addr1 = 12'h002;
        step(w);
        bus.req1 = 1'b0;
        #1;
        check("rv1_before_rst", bus.rvalid1, 1'b1);
        reset = 1'b1;
        #1;
        check("rv1_async_clr", bus.rvalid1, 1'b0);
        check("rd1_async_clr", bus.rdata1, 32'h0);
        check("gnt_in_rst", {bus.gnt0, bus.gnt1, bus.ram_wEn}, 3'b000);
        @(negedge clock);
        reset = 1'b0;
        model_reset();
        bus.req0 = 1'b1; bus.addr0 = 12'h005;
        bus.req1 = 1'b1; bus.addr1 = 12'h006;
        step(w);
        check("post_rst_first_p0", obs_g0, 1'b1);
        idle_inputs();
        step(w);

        // Port 1 write followed by port 0 read of the same word
        bus.req1 = 1'b1; bus.we1 = 1'b1; bus.addr1 = 12'h0FF; bus.wdata1 = 32'h12345678;
        step(w);
        idle_inputs();
        bus.req0 = 1'b1; bus.addr0 = 12'h0FF;
        step(w);
        bus.req0 = 1'b0;
        #1;
        check("p1wr_p0rd", bus.rdata0, 32'h12345678);
        step(w);

        // Randomized traffic: requests held until granted, occasional withdrawal
        p0_act = 1'b0;
        p1_act = 1'b0;
        w = -1;
        for (int c = 0; c < 3000; c++) begin
            if (p0_act && w != 0 && $urandom_range(0, 7) == 0) p0_act = 1'b0;
            else if (!p0_act || w == 0) begin
                p0_act     = ($urandom_range(0, 3) != 0);
                bus.we0    = $urandom_range(0, 1) == 1;
                bus.addr0  = 12'($urandom_range(0, 15));
                bus.wdata0 = $urandom;
            end
            if (p1_act && w != 1 && $urandom_range(0, 7) == 0) p1_act = 1'b0;
            else if (!p1_act || w == 1) begin
                p1_act     = ($urandom_range(0, 3) != 0);
                bus.we1    = $urandom_range(0, 1) == 1;
                bus.addr1  = 12'($urandom_range(0, 15));
                bus.wdata1 = $urandom;
            end
            if ($urandom_range(0, 9) == 0) bus.lock1 = ~bus.lock1;
            bus.req0 = p0_act;
            bus.req1 = p1_act;
            step(w);
        end
        idle_inputs();
        step(w);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
